btn_event_decoder: RTL and testbench
====================================

# btn_event_decoder

Classifies the debounced push-button level into discrete user events: short press, long press, and double press. Each event is a single-cycle pulse. The block sits downstream of the button debouncer: it reads the input direction of the user interface, where the LED controller drives the output direction. Its pulses feed mode and blink-control logic.

## Interface
- LONG_CYCLES, default 50_000_000: consecutive held edges after the press edge that qualify a long press (1 s at 50 MHz). Must be ≥ 2.
- DBL_GAP_CYCLES, default 12_500_000: maximum release-gap edges before a second press is no longer a double (250 ms). Must be ≥ 2.
- CNT_W, default 26: counter width. Must hold max(LONG_CYCLES, DBL_GAP_CYCLES) − 1.

Ports:
- clk  input  1  system clock. One clock domain.
- rst  input  1  asynchronous, active-high reset.
- btn_clean  input  1  debounced button level, already synchronous to clk. 1 = pressed.
- short_press  output  1  one-cycle pulse for a single short press.
- long_press  output  1  one-cycle pulse when the hold time reaches LONG_CYCLES.
- double_press  output  1  one-cycle pulse on release of the second press.
- busy  output  1  high whenever the FSM is not in IDLE.

## Operation
- Edge detect: btn_q is btn_clean registered. A rise is btn_clean=1 with btn_q=0. btn_q resets to 1, so a button held through reset is ignored until it is released and pressed again.
- All outputs are registered. Reset value of every output is 0.
- On reset: state = IDLE, cnt = 0. Reset takes effect immediately, including mid-sequence. No event pulse is generated for a sequence cut by reset.
- FSM states and transitions:
  - IDLE: on a rise, go to PRESS1 and set cnt ← 0.
  - PRESS1, btn_clean=1: if cnt == LONG_CYCLES−1, pulse long_press and go to LONG_HELD. Otherwise cnt++.
  - PRESS1, btn_clean=0: go to GAP and set cnt ← 0.
  - GAP, btn_clean=1: go to PRESS2. The press check has priority over timeout on the same edge.
  - GAP, btn_clean=0: if cnt == DBL_GAP_CYCLES−1, pulse short_press and go to IDLE. Otherwise cnt++.
  - PRESS2: on btn_clean=0, pulse double_press and go to IDLE. No long-press detection in PRESS2; holding is simply waited out.
  - LONG_HELD: on btn_clean=0, go to IDLE. No pulse.
- At most one event pulse per sequence. The three pulses are mutually exclusive.
- cnt never wraps. It is cleared on every state entry and stops at its compare value.
- busy = (state != IDLE), registered alongside the state.

## Timing
- Let E0 be the edge where the rise is sampled, and E1, E2, … the following edges.
- Long press: if btn_clean is sampled 1 at E1…E_L (L = LONG_CYCLES), long_press is high for exactly the cycle following E_L.
- Release: a 0 sampled at any E_k with k ≤ L goes to GAP. A release at E_L wins over the long-press qualification.
- Gap: let R0 be the release edge, and R1, R2, … the following edges.
  - btn_clean=0 at R1…R_G (G = DBL_GAP_CYCLES): short_press pulses after R_G.
  - btn_clean=1 at any R_k with k ≤ G: enter PRESS2.
- double_press pulses in the cycle after the edge where the second release is sampled.
- busy rises after E0 and falls after the edge that returns the FSM to IDLE.
- Back-to-back sequences: a rise sampled on the first IDLE edge starts a new sequence with no dead cycles. btn_q tracking continues in all states.

## Test plan
Parameters for all tests: LONG_CYCLES=8, DBL_GAP_CYCLES=5.
- Short press: btn high E0–E3, low thereafter. Required: short_press exactly 1 cycle after R5; long_press and double_press stay 0; busy stays high through R5.
- Long press: btn held 20 edges. Required: long_press only after E8, exactly one cycle; no short_press on release; busy falls after the release edge.
- Long boundary: btn high E0–E7, low at E8. Required: no long_press; short_press after R5. Repeat with btn high through E8: long_press pulses.
- Double press: high E0–E2, low R0–R3, high 3 edges, then low. Required: double_press one cycle after the second release; no short_press. Repeat with low R0–R5 before the second press: short_press after R5, then the second press is treated as a new sequence.
- Reset mid-sequence: assert rst asynchronously during PRESS1 at E4. Required: all outputs and busy go to 0 immediately; with btn still high after reset deasserts, no event until a release and a fresh press.
- Reset with button held: btn=1 across reset release. Required: no rise detected and busy stays 0; after btn is released and pressed again, normal detection resumes.

Source files
------------

// File: rtl/btn_event_decoder.sv
// Turns a debounced button level into one-cycle short/long/double press pulses, 1 cycle after the qualifying edge.
// No backpressure: pulses are fire-and-forget and the button can never be stalled.
module btn_event_decoder #(
  parameter int LONG_CYCLES    = 50_000_000,
  parameter int DBL_GAP_CYCLES = 12_500_000,
  parameter int CNT_W          = 26
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_clean,
  output logic short_press,
  output logic long_press,
  output logic double_press,
  output logic busy
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PRESS1,
    S_GAP,
    S_PRESS2,
    S_LONG_HELD
  } state_t;

  localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(DBL_GAP_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_btn_q;
  logic             w_rise;

  // r_btn_q resets high so a button held through reset needs a fresh press
  assign w_rise = btn_clean & ~r_btn_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_btn_q      <= 1'b1;
      short_press  <= 1'b0;
      long_press   <= 1'b0;
      double_press <= 1'b0;
      busy         <= 1'b0;
    end else begin
      r_btn_q      <= btn_clean;
      short_press  <= 1'b0;
      long_press   <= 1'b0;
      double_press <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_rise) begin
            r_state <= S_PRESS1;
            r_cnt   <= '0;
            busy    <= 1'b1;
          end
        end
        S_PRESS1: begin
          if (!btn_clean) begin
            r_state <= S_GAP;
            r_cnt   <= '0;
          end else if (r_cnt == LONG_LAST) begin
            long_press <= 1'b1;
            r_state    <= S_LONG_HELD;
            r_cnt      <= '0;
          end else begin
            r_cnt <= r_cnt + CNT_ONE;
          end
        end
        S_GAP: begin
          // a press on the timeout edge still counts as the second press
          if (btn_clean) begin
            r_state <= S_PRESS2;
            r_cnt   <= '0;
          end else if (r_cnt == GAP_LAST) begin
            short_press <= 1'b1;
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            busy        <= 1'b0;
          end else begin
            r_cnt <= r_cnt + CNT_ONE;
          end
        end
        S_PRESS2: begin
          if (!btn_clean) begin
            double_press <= 1'b1;
            r_state      <= S_IDLE;
            r_cnt        <= '0;
            busy         <= 1'b0;
          end
        end
        S_LONG_HELD: begin
          if (!btn_clean) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            busy    <= 1'b0;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_cnt   <= '0;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_btn_event_decoder.sv
// Bench for btn_event_decoder: expected pulses are queued with their edge number when stimulus is
// driven, and a negedge monitor pops and compares each observed pulse.
module tb_btn_event_decoder;

  localparam int LONG_CYCLES    = 8;
  localparam int DBL_GAP_CYCLES = 5;

  localparam logic [2:0] EV_SHORT  = 3'b001;
  localparam logic [2:0] EV_DOUBLE = 3'b010;
  localparam logic [2:0] EV_LONG   = 3'b100;

  typedef struct {
    logic [2:0] kind;
    int         edge_no;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  logic btn_clean;
  logic short_press;
  logic long_press;
  logic double_press;
  logic busy;

  int   n_cmp  = 0;
  int   n_bad  = 0;
  int   edge_n = 0;
  int   e0;
  exp_t sb_q[$];

  logic [2:0] mon_obs;
  exp_t       mon_e;

  btn_event_decoder #(
    .LONG_CYCLES   (LONG_CYCLES),
    .DBL_GAP_CYCLES(DBL_GAP_CYCLES),
    .CNT_W         (4)
  ) u_dut (
    .clk         (clk),
    .rst         (rst),
    .btn_clean   (btn_clean),
    .short_press (short_press),
    .long_press  (long_press),
    .double_press(double_press),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // One clock edge with btn_clean driven to b; returns 1 time unit after the edge
  task automatic tick(input logic b);
    @(negedge clk);
    btn_clean = b;
    @(posedge clk);
    edge_n++;
    #1;
  endtask

  task automatic hold(input logic b, input int n);
    for (int i = 0; i < n; i++) tick(b);
  endtask

  task automatic expect_evt(input logic [2:0] k, input int e);
    exp_t x;
    x.kind    = k;
    x.edge_no = e;
    sb_q.push_back(x);
  endtask

  task automatic drain(input string tag);
    chk(tag, sb_q.size(), 0);
    sb_q.delete();
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      mon_obs = {long_press, double_press, short_press};
      if (mon_obs != 3'b000) begin
        if (sb_q.size() == 0) begin
          chk("evt_unexpected", {29'd0, mon_obs}, 32'd0);
        end else begin
          mon_e = sb_q.pop_front();
          chk("evt_kind", {29'd0, mon_obs}, {29'd0, mon_e.kind});
          chk("evt_edge", edge_n, mon_e.edge_no);
        end
      end
    end
  end

  initial begin
    rst       = 1'b1;
    btn_clean = 1'b0;
    hold(1'b0, 2);
    chk("rst_short",  {31'd0, short_press},  0);
    chk("rst_long",   {31'd0, long_press},   0);
    chk("rst_double", {31'd0, double_press}, 0);
    chk("rst_busy",   {31'd0, busy},         0);
    rst = 1'b0;
    hold(1'b0, 3);

    // Short press: high E0-E3, release at E4=R0, pulse after R5
    e0 = edge_n + 1;
    expect_evt(EV_SHORT, e0 + 4 + DBL_GAP_CYCLES);
    hold(1'b1, 1);
    chk("short_busy_rise", {31'd0, busy}, 1);
    hold(1'b1, 3);
    hold(1'b0, 5);
    chk("short_busy_r4", {31'd0, busy}, 1);
    hold(1'b0, 1);
    chk("short_busy_r5", {31'd0, busy}, 0);
    hold(1'b0, 3);
    drain("short_drain");

    // Long press: held 20 edges
    e0 = edge_n + 1;
    expect_evt(EV_LONG, e0 + LONG_CYCLES);
    hold(1'b1, 20);
    chk("long_busy_held", {31'd0, busy}, 1);
    hold(1'b0, 1);
    chk("long_busy_release", {31'd0, busy}, 0);
    hold(1'b0, 8);
    drain("long_drain");

    // Release exactly at E8 beats long qualification
    e0 = edge_n + 1;
    expect_evt(EV_SHORT, e0 + LONG_CYCLES + DBL_GAP_CYCLES);
    hold(1'b1, 8);
    hold(1'b0, 10);
    drain("long_edge_minus_drain");

    // Held through E8 gives long press
    e0 = edge_n + 1;
    expect_evt(EV_LONG, e0 + LONG_CYCLES);
    hold(1'b1, 9);
    hold(1'b0, 3);
    drain("long_edge_exact_drain");

    // Double press: second press at R4
    e0 = edge_n + 1;
    expect_evt(EV_DOUBLE, e0 + 10);
    hold(1'b1, 3);
    hold(1'b0, 4);
    hold(1'b1, 3);
    hold(1'b0, 5);
    drain("double_drain");

    // Gap too long: short after R5, then a new sequence back-to-back
    e0 = edge_n + 1;
    expect_evt(EV_SHORT, e0 + 3 + DBL_GAP_CYCLES);
    expect_evt(EV_SHORT, e0 + 9 + 3 + DBL_GAP_CYCLES);
    hold(1'b1, 3);
    hold(1'b0, 6);
    hold(1'b1, 3);
    hold(1'b0, 10);
    drain("gap_timeout_drain");

    // Asynchronous reset during PRESS1 at E4
    hold(1'b1, 5);
    chk("rst_mid_busy_before", {31'd0, busy}, 1);
    #1 rst = 1'b1;
    #1;
    chk("rst_mid_busy",   {31'd0, busy}, 0);
    chk("rst_mid_events", {29'd0, long_press, double_press, short_press}, 0);
    hold(1'b1, 2);
    rst = 1'b0;
    hold(1'b1, 12);
    chk("rst_mid_no_rise", {31'd0, busy}, 0);
    hold(1'b0, 2);
    e0 = edge_n + 1;
    expect_evt(EV_SHORT, e0 + 4 + DBL_GAP_CYCLES);
    hold(1'b1, 4);
    hold(1'b0, 10);
    drain("rst_mid_drain");

    // Button held across reset release
    rst = 1'b1;
    hold(1'b1, 3);
    rst = 1'b0;
    hold(1'b1, 10);
    chk("rst_held_busy", {31'd0, busy}, 0);
    hold(1'b0, 2);
    e0 = edge_n + 1;
    expect_evt(EV_LONG, e0 + LONG_CYCLES);
    hold(1'b1, 10);
    chk("rst_held_resume_busy", {31'd0, busy}, 1);
    hold(1'b0, 1);
    chk("rst_held_idle", {31'd0, busy}, 0);
    hold(1'b0, 3);
    drain("rst_held_drain");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
